// File: rtl/mem_write_scoreboard.sv
// Watches the core's data-memory write port and scores each write against a
// preloaded table of expected {address, data} pairs, with a PASS/FAIL verdict.
module mem_write_scoreboard #(
  parameter int DEPTH   = 8,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int ORDERED = 1,
  parameter int STRICT  = 0,
  parameter int TIMEOUT = 1000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_en,
  input  logic [AW-1:0]              load_addr,
  input  logic [DW-1:0]              load_data,
  input  logic                       start,
  input  logic                       memwrite,
  input  logic [AW-1:0]              dataadr,
  input  logic [DW-1:0]              writedata,
  output logic                       done,
  output logic                       pass,
  output logic                       fail,
  output logic [$clog2(DEPTH+1)-1:0] match_count,
  output logic [15:0]                mismatch_count,
  output logic [$clog2(DEPTH+1)-1:0] num_exp
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;
  state_t state, next_state;

  logic [AW-1:0]    tab_addr [DEPTH];
  logic [DW-1:0]    tab_data [DEPTH];
  logic [DEPTH-1:0] matched;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    hit_idx;
  logic [31:0]      timer;
  logic             hit, sample, match, miss, complete, timed_out, arm, load_ok;

  // Scanning downward leaves the lowest-index unmatched candidate in hit_idx.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    if (ORDERED != 0) begin
      hit     = (tab_addr[ptr] == dataadr) && (tab_data[ptr] == writedata);
      hit_idx = ptr;
    end else begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if ((CW'(i) < num_exp) && !matched[i] &&
            (tab_addr[i] == dataadr) && (tab_data[i] == writedata)) begin
          hit     = 1'b1;
          hit_idx = IW'(i);
        end
      end
    end
  end

  assign sample    = (state == S_RUN) && memwrite;
  assign match     = sample && hit;
  assign miss      = sample && !hit;
  assign complete  = match && ((match_count + CW'(1)) == num_exp);
  assign timed_out = (TIMEOUT != 0) && (timer == 32'(TIMEOUT - 1));
  assign arm       = start && (state != S_RUN);
  assign load_ok   = (state == S_IDLE) && load_en && !start && (num_exp < CW'(DEPTH));

  // A final match takes precedence over both a strict mismatch and the timeout.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE, S_PASS, S_FAIL: begin
        if (start) next_state = (num_exp == '0) ? S_PASS : S_RUN;
      end
      S_RUN: begin
        if (complete)                                next_state = S_PASS;
        else if ((STRICT != 0 && miss) || timed_out) next_state = S_FAIL;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      num_exp        <= '0;
      match_count    <= '0;
      mismatch_count <= '0;
      matched        <= '0;
      ptr            <= '0;
      timer          <= '0;
    end else begin
      state <= next_state;
      if (arm) begin
        match_count    <= '0;
        mismatch_count <= '0;
        matched        <= '0;
        ptr            <= '0;
        timer          <= '0;
      end else if (state == S_RUN) begin
        timer <= timer + 32'd1;
        if (match) begin
          match_count      <= match_count + CW'(1);
          ptr              <= ptr + IW'(1);
          matched[hit_idx] <= 1'b1;
        end
        if (miss && (mismatch_count != 16'hFFFF))
          mismatch_count <= mismatch_count + 16'd1;
      end
      if (load_ok) num_exp <= num_exp + CW'(1);
    end
  end

  // Table contents survive reset; only num_exp decides which entries are live.
  always_ff @(posedge clk) begin
    if (!reset && load_ok) begin
      tab_addr[num_exp[IW-1:0]] <= load_addr;
      tab_data[num_exp[IW-1:0]] <= load_data;
    end
  end

  assign pass = (state == S_PASS);
  assign fail = (state == S_FAIL);
  assign done = pass || fail;

endmodule

// File: tb/tb_mem_write_scoreboard.sv
// Directed bench: four scoreboards with different ORDERED/STRICT/TIMEOUT settings
// share one stimulus bus; index 0 ordered, 1 ordered+strict, 2 any-order, 3 timeout=20.
module tb_mem_write_scoreboard;
  logic        clk = 1'b0;
  logic        reset, load_en, start, memwrite;
  logic [31:0] load_addr, load_data, dataadr, writedata;

  logic [3:0]       done_v, pass_v, fail_v;
  logic [3:0][3:0]  mc_v, ne_v;
  logic [3:0][15:0] mm_v;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] TA [5] = '{32'd52, 32'd32, 32'd28, 32'd24, 32'd20};
  localparam logic [31:0] TD [5] = '{32'd1,  32'd3,  32'd6,  32'd9,  32'd28};

  always #5 clk = ~clk;

  mem_write_scoreboard #(.DEPTH(8), .AW(32), .DW(32), .ORDERED(1), .STRICT(0), .TIMEOUT(1000)) dut_ord (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .start(start), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .done(done_v[0]), .pass(pass_v[0]), .fail(fail_v[0]),
    .match_count(mc_v[0]), .mismatch_count(mm_v[0]), .num_exp(ne_v[0]));

  mem_write_scoreboard #(.DEPTH(8), .AW(32), .DW(32), .ORDERED(1), .STRICT(1), .TIMEOUT(1000)) dut_strict (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .start(start), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .done(done_v[1]), .pass(pass_v[1]), .fail(fail_v[1]),
    .match_count(mc_v[1]), .mismatch_count(mm_v[1]), .num_exp(ne_v[1]));

  mem_write_scoreboard #(.DEPTH(8), .AW(32), .DW(32), .ORDERED(0), .STRICT(0), .TIMEOUT(1000)) dut_any (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .start(start), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .done(done_v[2]), .pass(pass_v[2]), .fail(fail_v[2]),
    .match_count(mc_v[2]), .mismatch_count(mm_v[2]), .num_exp(ne_v[2]));

  mem_write_scoreboard #(.DEPTH(8), .AW(32), .DW(32), .ORDERED(1), .STRICT(0), .TIMEOUT(20)) dut_tmo (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .start(start), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .done(done_v[3]), .pass(pass_v[3]), .fail(fail_v[3]),
    .match_count(mc_v[3]), .mismatch_count(mm_v[3]), .num_exp(ne_v[3]));

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every helper returns 1 time unit after a rising edge, so outputs are stable.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  task automatic load_entry(input logic [31:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    step(1);
    load_en = 1'b0;
  endtask

  task automatic load_table();
    for (int i = 0; i < 5; i++) load_entry(TA[i], TD[i]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1; dataadr = a; writedata = d;
    step(1);
    memwrite = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load_en = 1'b0; start = 1'b0; memwrite = 1'b0;
    load_addr = '0; load_data = '0; dataadr = '0; writedata = '0;
    step(2);
    reset = 1'b0;
    checkOutput("reset_done", 32'(done_v), 32'h0);
    checkOutput("reset_num_exp", 32'(ne_v[0]), 32'd0);
    checkOutput("reset_match", 32'(mc_v[0]), 32'd0);

    // In-order pass with idle gaps between writes
    $display("[TB] ordered pass");
    load_table();
    checkOutput("load_num_exp", 32'(ne_v[0]), 32'd5);
    pulse_start();
    checkOutput("run_not_done", 32'(done_v), 32'h0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(TA[i], TD[i]);
      step(1);
    end
    checkOutput("ord_no_early_pass", 32'(pass_v), 32'h0);
    checkOutput("ord_match4", 32'(mc_v[0]), 32'd4);
    applyStimulus(TA[4], TD[4]);
    checkOutput("ord_pass_all", 32'(pass_v), 32'hF);
    checkOutput("ord_done", 32'(done_v[0]), 32'd1);
    checkOutput("ord_match5", 32'(mc_v[0]), 32'd5);
    checkOutput("ord_mismatch0", 32'(mm_v[0]), 32'd0);
    applyStimulus(32'd99, 32'd99);
    checkOutput("post_verdict_ignored", 32'(mm_v[0]), 32'd0);
    checkOutput("post_verdict_hold", 32'(pass_v[0]), 32'd1);

    // Re-run with the stored table; first write is out of order
    $display("[TB] order violation");
    pulse_start();
    checkOutput("rerun_cleared", 32'(mc_v[0]), 32'd0);
    checkOutput("rerun_running", 32'(done_v), 32'h0);
    applyStimulus(32'd32, 32'd3);
    checkOutput("strict_fail", 32'(fail_v[1]), 32'd1);
    checkOutput("strict_match", 32'(mc_v[1]), 32'd0);
    checkOutput("strict_mismatch", 32'(mm_v[1]), 32'd1);
    checkOutput("tolerant_running", 32'(done_v[0]), 32'd0);
    checkOutput("tolerant_mismatch", 32'(mm_v[0]), 32'd1);
    checkOutput("any_first_match", 32'(mc_v[2]), 32'd1);

    // Any-order: reverse sequence plus a duplicate of (24,9)
    $display("[TB] any order");
    do_reset();
    load_table();
    pulse_start();
    applyStimulus(32'd20, 32'd28);
    applyStimulus(32'd24, 32'd9);
    applyStimulus(32'd24, 32'd9);
    applyStimulus(32'd28, 32'd6);
    applyStimulus(32'd32, 32'd3);
    checkOutput("any_no_early_pass", 32'(pass_v[2]), 32'd0);
    checkOutput("any_match4", 32'(mc_v[2]), 32'd4);
    applyStimulus(32'd52, 32'd1);
    checkOutput("any_pass", 32'(pass_v[2]), 32'd1);
    checkOutput("any_match5", 32'(mc_v[2]), 32'd5);
    checkOutput("any_dup_mismatch", 32'(mm_v[2]), 32'd1);
    checkOutput("ord_rev_match", 32'(mc_v[0]), 32'd1);
    checkOutput("ord_rev_mismatch", 32'(mm_v[0]), 32'd5);

    // Timeout of 20 RUN cycles
    $display("[TB] timeout");
    do_reset();
    load_entry(32'd52, 32'd1);
    load_entry(32'd32, 32'd3);
    pulse_start();
    applyStimulus(32'd52, 32'd1);
    step(18);
    checkOutput("tmo_not_yet", 32'(fail_v[3]), 32'd0);
    step(1);
    checkOutput("tmo_fail", 32'(fail_v[3]), 32'd1);
    checkOutput("tmo_match", 32'(mc_v[3]), 32'd1);
    checkOutput("long_tmo_running", 32'(done_v[0]), 32'd0);
    pulse_start();
    applyStimulus(32'd52, 32'd1);
    step(18);
    checkOutput("tmo_edge_running", 32'(done_v[3]), 32'd0);
    applyStimulus(32'd32, 32'd3);
    checkOutput("tmo_edge_pass", 32'(pass_v[3]), 32'd1);
    checkOutput("tmo_edge_no_fail", 32'(fail_v[3]), 32'd0);

    // Table bounds, empty start, start-over-load priority
    $display("[TB] table bounds");
    do_reset();
    pulse_start();
    checkOutput("empty_pass", 32'(pass_v), 32'hF);
    checkOutput("empty_match", 32'(mc_v[0]), 32'd0);
    load_entry(32'd4, 32'd4);
    checkOutput("load_outside_idle", 32'(ne_v[0]), 32'd0);
    do_reset();
    for (int i = 0; i < 10; i++) load_entry(32'(i * 4), 32'(i));
    checkOutput("load_saturate", 32'(ne_v[0]), 32'd8);
    do_reset();
    load_entry(32'd8, 32'd8);
    start = 1'b1; load_en = 1'b1; load_addr = 32'd12; load_data = 32'd12;
    step(1);
    start = 1'b0; load_en = 1'b0;
    checkOutput("start_drops_load", 32'(ne_v[0]), 32'd1);
    checkOutput("start_runs", 32'(done_v[0]), 32'd0);

    // Reset in the middle of a run
    $display("[TB] reset mid-run");
    do_reset();
    load_table();
    pulse_start();
    applyStimulus(32'd52, 32'd1);
    applyStimulus(32'd32, 32'd3);
    checkOutput("mid_match2", 32'(mc_v[0]), 32'd2);
    do_reset();
    checkOutput("mid_reset_done", 32'(done_v), 32'h0);
    checkOutput("mid_reset_match", 32'(mc_v[0]), 32'd0);
    checkOutput("mid_reset_num_exp", 32'(ne_v[0]), 32'd0);
    load_entry(32'd52, 32'd1);
    checkOutput("reload_accepted", 32'(ne_v[0]), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
